// File: rtl/lockstep_mem_responder_if.sv
// ---------------------------------------------------------------------------
// lockstep_mem_responder_if
// Bus bundle between two lockstep cores and the shared memory responder.
//   req0_i/req1_i       request from core 0 / core 1
//   addr0_i/addr1_i     byte address
//   we0_i/we1_i         write enable
//   be0_i/be1_i         byte enables
//   wdata0_i/wdata1_i   write data
//   gnt_o               grant (combinational, common to both cores)
//   rvalid_o            response valid, one cycle after gnt_o
//   rdata_o             read data (0 unless a read response is valid)
//   err_o               error response, qualified by rvalid_o
//   mismatch_o          one-cycle pulse on a lockstep divergence
//   mismatch_cnt_o      saturating divergence count
// Modports: slave = responder side, master = core/bench side.
// ---------------------------------------------------------------------------
interface lockstep_mem_responder_if;
  logic        req0_i;
  logic        req1_i;
  logic [31:0] addr0_i;
  logic [31:0] addr1_i;
  logic        we0_i;
  logic        we1_i;
  logic [3:0]  be0_i;
  logic [3:0]  be1_i;
  logic [31:0] wdata0_i;
  logic [31:0] wdata1_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        mismatch_o;
  logic [7:0]  mismatch_cnt_o;

  modport slave (
    input  req0_i, req1_i, addr0_i, addr1_i, we0_i, we1_i,
    input  be0_i, be1_i, wdata0_i, wdata1_i,
    output gnt_o, rvalid_o, rdata_o, err_o, mismatch_o, mismatch_cnt_o
  );

  modport master (
    output req0_i, req1_i, addr0_i, addr1_i, we0_i, we1_i,
    output be0_i, be1_i, wdata0_i, wdata1_i,
    input  gnt_o, rvalid_o, rdata_o, err_o, mismatch_o, mismatch_cnt_o
  );
endinterface

// File: rtl/lockstep_mem_responder.sv
// ---------------------------------------------------------------------------
// lockstep_mem_responder
// Single-port 2^AW x 32-bit memory serving two cores that run in lockstep.
// With LOCKSTEP_CMP_EN defined, both cores must issue identical requests;
// a lone request waits up to TIMEOUT cycles for its peer, and divergence
// (mismatch or timeout) is answered with an error response, a mismatch_o
// pulse and a saturating count. With LOCKSTEP_CMP_EN undefined, core 1 is
// ignored and core 0 is served directly.
// Configuration macro: LOCKSTEP_CMP_EN
// Ports:
//   clk_i  - clock, all logic on the rising edge
//   rst_i  - synchronous active-high reset (memory contents are kept)
//   bus    - lockstep_mem_responder_if.slave (requests in, response out)
// Parameters:
//   AW      - word-address width (memory depth 2^AW words)
//   TIMEOUT - peer wait limit in cycles, 1..15
// ---------------------------------------------------------------------------
module lockstep_mem_responder #(
  parameter int AW      = 10,
  parameter int TIMEOUT = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  lockstep_mem_responder_if.slave   bus
);

  localparam int DEPTH = 1 << AW;

  // Attributes of the transaction granted this cycle
  logic          w_gnt;
  logic          w_mm;
  logic [31:0]   w_addr;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_oor;
  logic          w_err;
  logic          w_wr;
  logic          w_rd;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_rdata_word;

  // Response stage: a one-deep register, independent of the FSM
  logic          r_rvalid;
  logic          r_err;
  logic          r_rd;

`ifdef LOCKSTEP_CMP_EN
  typedef enum logic {S_IDLE, S_WAIT_PEER} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_wait_cnt, w_wait_cnt_next;
  logic        r_first, w_first_next;   // which core opened the wait: 0/1
  logic        w_first_req, w_peer_req;
  logic [4:0]  w_cnt_inc;
  logic        w_gnt_raw, w_mm_raw, w_sel1;
  logic        w_match;
  logic        r_mm;
  logic [7:0]  r_mm_cnt;

  // wdata only matters for writes
  assign w_match = (bus.addr0_i == bus.addr1_i) && (bus.we0_i == bus.we1_i) &&
                   (bus.be0_i == bus.be1_i) &&
                   (!bus.we0_i || (bus.wdata0_i == bus.wdata1_i));

  always_comb begin
    w_state_next    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    w_first_next    = r_first;
    w_gnt_raw       = 1'b0;
    w_mm_raw        = 1'b0;
    w_sel1          = 1'b0;
    w_first_req     = r_first ? bus.req1_i : bus.req0_i;
    w_peer_req      = r_first ? bus.req0_i : bus.req1_i;
    w_cnt_inc       = {1'b0, r_wait_cnt} + 5'd1;
    case (r_state)
      S_IDLE: begin
        if (bus.req0_i && bus.req1_i) begin
          w_gnt_raw = 1'b1;
          w_mm_raw  = !w_match;
        end else if (bus.req0_i || bus.req1_i) begin
          w_state_next    = S_WAIT_PEER;
          w_wait_cnt_next = 4'd0;
          w_first_next    = bus.req1_i;
        end
      end
      S_WAIT_PEER: begin
        if (!w_first_req) begin
          // First requester withdrew: silently drop the attempt
          w_state_next = S_IDLE;
        end else if (w_peer_req) begin
          w_gnt_raw    = 1'b1;
          w_mm_raw     = !w_match;
          w_state_next = S_IDLE;
        end else if (w_cnt_inc == 5'(TIMEOUT)) begin
          // The cycle spent in IDLE counts as the first waiting cycle, so the
          // grant lands after exactly TIMEOUT cycles without gnt_o.
          w_gnt_raw    = 1'b1;
          w_mm_raw     = 1'b1;
          w_sel1       = r_first;
          w_state_next = S_IDLE;
        end else begin
          w_wait_cnt_next = w_cnt_inc[3:0];
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 4'd0;
      r_first    <= 1'b0;
      r_mm       <= 1'b0;
      r_mm_cnt   <= 8'd0;
    end else begin
      r_state    <= w_state_next;
      r_wait_cnt <= w_wait_cnt_next;
      r_first    <= w_first_next;
      r_mm       <= w_mm;
      if (w_mm && (r_mm_cnt != 8'hFF)) begin
        r_mm_cnt <= r_mm_cnt + 8'd1;
      end
    end
  end

  assign w_gnt   = w_gnt_raw & ~rst_i;
  assign w_mm    = w_mm_raw & ~rst_i;
  assign w_addr  = w_sel1 ? bus.addr1_i  : bus.addr0_i;
  assign w_we    = w_sel1 ? bus.we1_i    : bus.we0_i;
  assign w_be    = w_sel1 ? bus.be1_i    : bus.be0_i;
  assign w_wdata = w_sel1 ? bus.wdata1_i : bus.wdata0_i;

  assign bus.mismatch_o     = r_mm;
  assign bus.mismatch_cnt_o = r_mm_cnt;
`else
  logic w_unused_core1;

  assign w_gnt   = bus.req0_i & ~rst_i;
  assign w_mm    = 1'b0;
  assign w_addr  = bus.addr0_i;
  assign w_we    = bus.we0_i;
  assign w_be    = bus.be0_i;
  assign w_wdata = bus.wdata0_i;

  assign w_unused_core1 = ^{bus.req1_i, bus.addr1_i, bus.we1_i, bus.be1_i,
                            bus.wdata1_i, TIMEOUT[3:0]};

  assign bus.mismatch_o     = 1'b0;
  assign bus.mismatch_cnt_o = 8'd0;
`endif

  logic w_unused_lsb;
  assign w_unused_lsb = ^w_addr[1:0];

  // Out-of-range addresses error out but are not a lockstep divergence
  assign w_oor = |w_addr[31:AW+2];
  assign w_idx = w_addr[AW+1:2];
  assign w_err = w_mm | w_oor;
  assign w_wr  = w_gnt & w_we & ~w_err;
  assign w_rd  = w_gnt & ~w_we & ~w_err;

  // One block RAM per byte lane so byte enables map onto plain writes.
  // A read lands one cycle after its grant, so a write in the previous
  // cycle is already in the array (write-first from the core's view).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];
      logic [7:0] r_q;
      always_ff @(posedge clk_i) begin
        if (w_wr && w_be[gi]) begin
          r_mem[w_idx] <= w_wdata[gi*8 +: 8];
        end
        if (w_rd) begin
          r_q <= r_mem[w_idx];
        end
      end
      assign w_rdata_word[gi*8 +: 8] = r_q;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      r_err    <= w_gnt & w_err;
      r_rd     <= w_rd;
    end
  end

  // Gating with rst_i kills a response that is pending while reset is high;
  // the RAM output register itself is never reset, so rdata is masked here.
  assign bus.gnt_o    = w_gnt;
  assign bus.rvalid_o = r_rvalid & ~rst_i;
  assign bus.err_o    = r_err & ~rst_i;
  assign bus.rdata_o  = (r_rd & ~rst_i) ? w_rdata_word : 32'd0;

endmodule

// File: tb/tb_lockstep_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lockstep_mem_responder
// Directed plus random transactions against a transaction-level model of the
// responder (word array, expected response and mismatch count). Core-0
// attributes describe every granted transaction. Works with and without
// LOCKSTEP_CMP_EN.
// ---------------------------------------------------------------------------
module tb_lockstep_mem_responder;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lockstep_mem_responder_if bus ();

  lockstep_mem_responder #(.AW(AW), .TIMEOUT(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Bench addresses stay within words 0..63 when in range
  logic [31:0] model_mem [64];
  logic        exp_rv = 1'b0, exp_err = 1'b0, exp_mm = 1'b0;
  logic [31:0] exp_rdata = 32'd0;
  int          exp_cnt = 0;

  logic        r0, r1, w0, w1;
  logic [31:0] a0, a1, d0, d1;
  logic [3:0]  b0, b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    bus.req0_i = r0; bus.addr0_i = a0; bus.we0_i = w0; bus.be0_i = b0; bus.wdata0_i = d0;
    bus.req1_i = r1; bus.addr1_i = a1; bus.we1_i = w1; bus.be1_i = b1; bus.wdata1_i = d1;
  endtask

  task automatic set0(input logic r, input logic [31:0] a, input logic w,
                      input logic [3:0] b, input logic [31:0] d);
    r0 = r; a0 = a; w0 = w; b0 = b; d0 = d;
  endtask

  // Core 1 copies core 0 when lockstep is checked, otherwise it is noise
  task automatic mirror();
`ifdef LOCKSTEP_CMP_EN
    r1 = r0; a1 = a0; w1 = w0; b1 = b0; d1 = d0;
`else
    r1 = 1'($urandom_range(0, 1)); a1 = $urandom; w1 = 1'($urandom_range(0, 1));
    b1 = 4'($urandom_range(0, 15)); d1 = $urandom;
`endif
    drive();
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    return |a[31:AW+2];
  endfunction

  // One clock: check outputs for the current cycle, then advance the model
  task automatic cycle(input logic g, input logic e, input logic mm);
    int idx;
    #1;
    check("gnt", {31'd0, bus.gnt_o}, {31'd0, g});
    check("rvalid", {31'd0, bus.rvalid_o}, {31'd0, exp_rv && !rst});
    check("rdata", bus.rdata_o, rst ? 32'd0 : exp_rdata);
    check("err", {31'd0, bus.err_o}, {31'd0, exp_err && !rst});
    check("mismatch", {31'd0, bus.mismatch_o}, {31'd0, exp_mm});
    check("mismatch_cnt", {24'd0, bus.mismatch_cnt_o}, 32'(exp_cnt));
    @(posedge clk);
    if (rst) begin
      exp_rv = 0; exp_err = 0; exp_mm = 0; exp_rdata = 0; exp_cnt = 0;
    end else begin
      exp_rv    = g;
      exp_err   = g && e;
      exp_mm    = mm;
      exp_rdata = 32'd0;
      if (mm && exp_cnt < 255) exp_cnt++;
      if (g && !e) begin
        idx = int'(a0[7:2]);
        if (w0) begin
          for (int b = 0; b < 4; b++)
            if (b0[b]) model_mem[idx][b*8 +: 8] = d0[b*8 +: 8];
        end else begin
          exp_rdata = model_mem[idx];
        end
      end
    end
    $display("cycle t=%0t req0=%0b addr0=%h we0=%0b be0=%h gnt_exp=%0b err_exp=%0b rdata_exp=%h cnt_exp=%0d",
             $time, r0, a0, w0, b0, g, e, exp_rdata, exp_cnt);
    #1;
  endtask

  initial begin
    logic oor;
    rst = 1'b1;
    set0(0, 0, 0, 0, 0); r1 = 0; a1 = 0; w1 = 0; b1 = 0; d1 = 0; drive();
    @(posedge clk); #1;

    // Reset with a request present: no grant, everything zero
    set0(1, 32'h10, 0, 4'hF, 0); mirror();
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    rst = 1'b0;

    // Fill words 0..63 back to back
    for (int w = 0; w < 64; w++) begin
      set0(1, 32'(w) << 2, 1, 4'hF, $urandom); mirror();
      cycle(1, 0, 0);
    end

    // Random mix of reads/writes, idles and out-of-range accesses
    for (int n = 0; n < 200; n++) begin
      oor = ($urandom_range(0, 9) == 0);
      set0($urandom_range(0, 9) != 0,
           oor ? ($urandom | 32'h0001_0000) : ((32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3))),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
      mirror();
      cycle(r0, oor, 0);
    end

    // Write then read 0x10
    set0(1, 32'h10, 1, 4'hF, 32'hDEADBEEF); mirror(); cycle(1, 0, 0);
    set0(1, 32'h10, 0, 4'hF, 0);            mirror(); cycle(1, 0, 0);
    check("deadbeef_read", bus.rdata_o, 32'hDEADBEEF);

    // Partial-byte write
    set0(1, 32'h40, 1, 4'hF, 32'h11223344);    mirror(); cycle(1, 0, 0);
    set0(1, 32'h40, 1, 4'b0101, 32'hAABBCCDD); mirror(); cycle(1, 0, 0);
    set0(1, 32'h40, 0, 4'h0, 0);               mirror(); cycle(1, 0, 0);
    check("byte_merge", bus.rdata_o, 32'h11BB33DD);

    // Out-of-range address
    set0(1, 32'h0001_0000, 0, 4'hF, 0); mirror(); cycle(1, 1, 0);
    check("oor_err", {31'd0, bus.err_o}, 32'd1);
    check("oor_no_mismatch", {31'd0, bus.mismatch_o}, 32'd0);

    // Reset right after a read grant kills its response; memory survives
    set0(1, 32'h10, 0, 4'hF, 0); mirror(); cycle(1, 0, 0);
    rst = 1'b1; set0(0, 0, 0, 0, 0); mirror(); cycle(0, 0, 0);
    rst = 1'b0; set0(0, 0, 0, 0, 0); mirror(); cycle(0, 0, 0);
    set0(1, 32'h10, 0, 4'hF, 0); mirror(); cycle(1, 0, 0);

`ifdef LOCKSTEP_CMP_EN
    // Divergent write data: error, no write
    set0(1, 32'h20, 1, 4'hF, 32'h1); mirror(); d1 = 32'h2; drive(); cycle(1, 1, 1);
    set0(1, 32'h20, 0, 4'hF, 0);     mirror(); cycle(1, 0, 0);

    // Lone request held: four cycles without grant, then timeout error
    set0(1, 32'h30, 0, 4'hF, 0); r1 = 0; a1 = 0; w1 = 0; b1 = 0; d1 = 0; drive();
    for (int k = 0; k < 4; k++) cycle(0, 0, 0);
    cycle(1, 1, 1);
    set0(0, 0, 0, 0, 0); mirror(); cycle(0, 0, 0);

    // Core 1 alone then withdraws: no grant, no response
    set0(0, 0, 0, 0, 0); r1 = 1; a1 = 32'h8; w1 = 0; b1 = 4'hF; d1 = 0; drive();
    cycle(0, 0, 0); cycle(0, 0, 0);
    r1 = 0; drive(); cycle(0, 0, 0);
    set0(1, 32'h8, 0, 4'hF, 0); mirror(); cycle(1, 0, 0);

    // Peer joins late with a match
    set0(1, 32'h34, 1, 4'b0011, $urandom); r1 = 0; drive();
    cycle(0, 0, 0); cycle(0, 0, 0);
    mirror(); cycle(1, 0, 0);

    // Peer joins late with different byte enables
    set0(1, 32'h38, 1, 4'hF, $urandom); r1 = 0; drive();
    cycle(0, 0, 0);
    mirror(); b1 = 4'h1; drive(); cycle(1, 1, 1);

    // Saturation of the divergence counter
    for (int k = 0; k < 300; k++) begin
      set0(1, 32'h4, 0, 4'hF, 0); mirror(); a1 = 32'h8; drive();
      cycle(1, 1, 1);
    end
    check("cnt_saturated", {24'd0, bus.mismatch_cnt_o}, 32'd255);
`else
    // Core 1 requesting alone is ignored
    set0(0, 0, 0, 0, 0); r1 = 1; a1 = 32'h4; w1 = 1; b1 = 4'hF; d1 = $urandom; drive();
    cycle(0, 0, 0);
    // Core 0 served despite a diverging core 1
    set0(1, 32'h4, 0, 4'hF, 0); r1 = 1; a1 = 32'h8; w1 = 1; b1 = 4'h3; d1 = $urandom; drive();
    cycle(1, 0, 0);
`endif

    set0(0, 0, 0, 0, 0); mirror(); cycle(0, 0, 0);
    set0(0, 0, 0, 0, 0); mirror(); cycle(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lockstep_mem_responder.md
LOCKSTEP_MEM_RESPONDER -- requirements
Module: lockstep_mem_responder

Interface
REQ-001 SHALL have parameter AW, default 10, word-address width; memory depth is 2^AW 32-bit words.
REQ-002 SHALL have parameter TIMEOUT, default 4, maximum number of cycles to wait for the peer request (range 1..15).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req0_i / req1_i, input, 1 each, request from core 0 and core 1.
REQ-006 SHALL have port addr0_i / addr1_i, input, 32 each, byte address.
REQ-007 SHALL have port we0_i / we1_i, input, 1 each, write enable.
REQ-008 SHALL have port be0_i / be1_i, input, 4 each, byte enables.
REQ-009 SHALL have port wdata0_i / wdata1_i, input, 32 each, write data.
REQ-010 SHALL have port gnt_o, output, 1, grant, common to both cores.
REQ-011 SHALL have port rvalid_o, output, 1, response valid, common to both cores.
REQ-012 SHALL have port rdata_o, output, 32, read data.
REQ-013 SHALL have port err_o, output, 1, error response, qualified by rvalid_o.
REQ-014 SHALL have port mismatch_o, output, 1, one-cycle pulse on a detected lockstep divergence.
REQ-015 SHALL have port mismatch_cnt_o, output, 8, saturating divergence count.

Function
REQ-016 SHALL implement FSM states IDLE and WAIT_PEER; the response stage is a separate one-deep register, not an FSM state.
REQ-017 Match: addr, we and be are equal; wdata is also compared when we=1.
REQ-018 IDLE, both requests, match: gnt_o=1 in the same cycle (combinational); the transaction is accepted.
REQ-019 IDLE, exactly one request: go to WAIT_PEER, load the wait counter with 0, gnt_o=0.
REQ-020 WAIT_PEER, peer request arrives with a match: gnt_o=1 that cycle, return to IDLE.
REQ-021 WAIT_PEER, counter reaches TIMEOUT with no peer request: gnt_o=1, accept as an error transaction (no write), pulse mismatch_o, return to IDLE.
REQ-022 WAIT_PEER, first requester deasserts req before the grant: return to IDLE, no response, no error.
REQ-023 Both requests in the same cycle with no match: gnt_o=1, error transaction (no write), pulse mismatch_o.
REQ-024 Whenever mismatch_o pulses, mismatch_cnt_o SHALL increment; it saturates at 255 and does not wrap.
REQ-025 Word index is addr[AW+1:2].
REQ-026 If addr[31:AW+2] is nonzero: error transaction with no write; this SHALL NOT pulse mismatch_o.
REQ-027 Accepted write: bytes with be=1 are written at the clock edge of the grant.
REQ-028 Accepted read: the full word is read, ignoring be.
REQ-029 Latency: rvalid_o=1 exactly one cycle after gnt_o.
  - Read: rdata_o = word.
  - Write or error: rdata_o = 0.
  - err_o=1 for error transactions.
REQ-030 Back-to-back grants SHALL be sustained at one per cycle, with rvalid_o for transaction N in the same cycle as gnt_o for transaction N+1.
REQ-031 A read to the address written in the previous cycle SHALL return the new data (write-first).
REQ-032 Whenever rvalid_o=0, rdata_o and err_o SHALL be 0.

Reset
REQ-033 When rst_i=1 at a clock edge, the following SHALL be cleared: FSM to IDLE, wait counter 0, rvalid_o 0, rdata_o 0, err_o 0, mismatch_o 0, mismatch_cnt_o 0.
REQ-034 While rst_i=1, gnt_o SHALL be 0.
REQ-035 Memory contents SHALL NOT be reset.
REQ-036 Reset in the cycle after a grant SHALL suppress the pending rvalid_o.

Configuration
REQ-037 Macro LOCKSTEP_CMP_EN defined: comparison, WAIT_PEER, mismatch_o and mismatch_cnt_o are implemented as above.
REQ-038 Macro LOCKSTEP_CMP_EN undefined:
  - All core-1 inputs are ignored and WAIT_PEER does not exist.
  - req0_i alone is granted in the same cycle.
  - mismatch_o and mismatch_cnt_o are tied to 0.
  - Out-of-range errors per REQ-026 still apply.

Verification
REQ-039 Both cores write addr 0x10, be=4'hF, wdata 0xDEADBEEF, then both read 0x10 -> gnt_o each cycle; read rvalid_o with rdata_o=0xDEADBEEF, err_o=0.
REQ-040 Both write addr 0x20 with wdata 0x1 vs 0x2 -> gnt_o=1, mismatch_o pulse, next cycle rvalid_o=1 err_o=1; subsequent read of 0x20 returns the prior contents.
REQ-041 req0_i only, held, TIMEOUT=4 -> no gnt_o for 4 cycles, then gnt_o=1, mismatch_cnt_o=1, err_o=1 on the response.
REQ-042 Write be=4'b0101 data 0xAABBCCDD over 0x11223344 -> read returns 0x11BB33DD.
REQ-043 Address 0x0001_0000 with AW=10 -> err_o=1, mismatch_o=0; 300 forced mismatches -> mismatch_cnt_o=255.
REQ-044 rst_i asserted the cycle after a read grant -> rvalid_o stays 0 and all outputs are 0 the next cycle.
